// File: rtl/logic_sweep_pkg.sv
// Shared types and the reference gate function for the logic sweep engine.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        ModeAnd  = 2'd0,
        ModeOr   = 2'd1,
        ModeXor  = 2'd2,
        ModeNand = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Evaluates the gate over the low n bits of v; bits above n are ignored.
    function automatic logic gate_op(mode_e m, logic [7:0] v, int n);
        logic [7:0] mask;
        logic       res;
        mask = 8'hff >> (8 - n);
        unique case (m)
            ModeAnd:  res = &(v | ~mask);
            ModeOr:   res = |(v & mask);
            ModeXor:  res = ^(v & mask);
            ModeNand: res = ~&(v | ~mask);
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_sweep_unit_gate_reduce.sv
// Combinational N-input gate: reduces the vector under the selected mode.
module gate_reduce
    import logic_sweep_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  mode_e          mode,
    input  logic [N-1:0]   v,
    output logic           y
);

    logic [7:0] v_ext;

    always_comb begin
        v_ext        = '0;
        v_ext[N-1:0] = v;
        y            = gate_op(mode, v_ext, int'(N));
    end

endmodule

// File: rtl/logic_sweep_unit.sv
// Self-running truth-table sweeper: walks all 2^N vectors, holding each STEP cycles,
// and counts how many of them drive the selected gate high.
module logic_sweep_unit
    import logic_sweep_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned STEP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    output logic [N-1:0] vec,
    output logic         f,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_count
);

    localparam int unsigned  DW        = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [N-1:0] VecLast   = '1;
    localparam logic [DW-1:0] DwellLast = DW'(STEP - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [N-1:0]  vec_q, vec_d;
    logic          f_q, f_d;
    logic [N:0]    ones_q, ones_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          accept;
    mode_e         mode_nxt;
    logic [N-1:0]  vec_nxt;
    logic          f_nxt;

    // The single gate instance always looks at the vector about to be loaded,
    // so f and ones_count update in the same cycle vec does.
    assign accept   = (state_q == StIdle) && start;
    assign mode_nxt = accept ? mode_e'(mode) : mode_q;
    assign vec_nxt  = accept ? '0 : vec_q + N'(1);

    gate_reduce #(
        .N (N)
    ) u_gate (
        .mode (mode_nxt),
        .v    (vec_nxt),
        .y    (f_nxt)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        vec_d   = vec_q;
        f_d     = f_q;
        ones_d  = ones_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    mode_d  = mode_e'(mode);
                    vec_d   = '0;
                    f_d     = f_nxt;
                    ones_d  = (N+1)'(f_nxt);
                    dwell_d = '0;
                end
            end
            StRun: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (vec_q != VecLast) begin
                        vec_d  = vec_nxt;
                        f_d    = f_nxt;
                        ones_d = ones_q + (N+1)'(f_nxt);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= ModeAnd;
            dwell_q <= '0;
            vec_q   <= '0;
            f_q     <= 1'b0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            vec_q   <= vec_d;
            f_q     <= f_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec        = vec_q;
    assign f          = f_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;

endmodule
